// File: rtl/regs_wb.sv
//------------------------------------------------------------------------------
// regs_wb : register-file write-back arbiter (ALU over 2-deep load queue) with
//           optional read forwarding, enabled by macro REGS_WB_FWD_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module regs_wb (
   input  logic        clk,
   input  logic        rst,
   input  logic        alu_valid,
   input  logic [3:0]  alu_reg,
   input  logic [31:0] alu_data,
   input  logic        ld_valid,
   input  logic [3:0]  ld_reg,
   input  logic [31:0] ld_data,
   output logic        ld_ready,
   output logic        wr_en,
   output logic [3:0]  wr_reg,
   output logic [31:0] wr_data,
   input  logic [3:0]  rd_reg_1,
   input  logic [3:0]  rd_reg_2,
   input  logic [31:0] rd_raw_1,
   input  logic [31:0] rd_raw_2,
   output logic [31:0] rd_data_1,
   output logic [31:0] rd_data_2,
   output logic        busy
);

   // Queue is kept compacted: slot 0 is always the head, r_v[1] implies r_v[0].
   logic [1:0]  r_v;
   logic [3:0]  r_reg  [0:1];
   logic [31:0] r_data [0:1];

   logic        w_accept, w_pop, w_direct, w_push, w_keep0, w_keep1;
   logic [1:0]  w_kill;
   logic        w_we;
   logic [3:0]  w_wreg;
   logic [31:0] w_wdata;
   logic [1:0]  w_nv;
   logic [3:0]  w_nreg  [0:1];
   logic [31:0] w_ndata [0:1];

   assign ld_ready = ~(r_v[0] & r_v[1]);
   assign busy     = |r_v;

   always_comb begin
      w_accept = ld_valid & ld_ready;
      w_kill[0] = alu_valid & r_v[0] & (r_reg[0] == alu_reg);
      w_kill[1] = alu_valid & r_v[1] & (r_reg[1] == alu_reg);
      w_pop    = ~alu_valid & r_v[0];
      w_direct = ~alu_valid & ~r_v[0] & w_accept;
      // An incoming load to the ALU's register is accepted but dropped.
      w_push   = w_accept & ~w_direct & ~(alu_valid & (ld_reg == alu_reg));
      w_keep0  = r_v[0] & ~w_kill[0] & ~w_pop;
      w_keep1  = r_v[1] & ~w_kill[1];

      w_we    = 1'b0;
      w_wreg  = alu_reg;
      w_wdata = alu_data;
      if (alu_valid) begin
         w_we = 1'b1;
      end else if (r_v[0]) begin
         w_we    = 1'b1;
         w_wreg  = r_reg[0];
         w_wdata = r_data[0];
      end else if (w_accept) begin
         w_we    = 1'b1;
         w_wreg  = ld_reg;
         w_wdata = ld_data;
      end

      w_nv       = 2'b00;
      w_nreg[0]  = ld_reg;
      w_ndata[0] = ld_data;
      w_nreg[1]  = ld_reg;
      w_ndata[1] = ld_data;
      if (w_keep0) begin
         w_nv[0]    = 1'b1;
         w_nreg[0]  = r_reg[0];
         w_ndata[0] = r_data[0];
         if (w_keep1) begin
            w_nv[1]    = 1'b1;
            w_nreg[1]  = r_reg[1];
            w_ndata[1] = r_data[1];
         end else begin
            w_nv[1] = w_push;
         end
      end else if (w_keep1) begin
         w_nv[0]    = 1'b1;
         w_nreg[0]  = r_reg[1];
         w_ndata[0] = r_data[1];
         w_nv[1]    = w_push;
      end else begin
         w_nv[0] = w_push;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_v     <= 2'b00;
         wr_en   <= 1'b0;
         wr_reg  <= 4'd0;
         wr_data <= 32'd0;
      end else begin
         r_v   <= w_nv;
         wr_en <= w_we;
         if (w_we) begin
            wr_reg  <= w_wreg;
            wr_data <= w_wdata;
         end
      end
   end

   // Slot payload needs no reset; only the valid bits carry meaning.
   always_ff @(posedge clk) begin
      r_reg[0]  <= w_nreg[0];
      r_data[0] <= w_ndata[0];
      r_reg[1]  <= w_nreg[1];
      r_data[1] <= w_ndata[1];
   end

`ifdef REGS_WB_FWD_EN
   logic        r_fwd_en;
   logic [3:0]  r_fwd_reg;
   logic [31:0] r_fwd_data;
   logic [3:0]  r_rd_reg_1;
   logic [3:0]  r_rd_reg_2;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_fwd_en   <= 1'b0;
         r_fwd_reg  <= 4'd0;
         r_fwd_data <= 32'd0;
         r_rd_reg_1 <= 4'd0;
         r_rd_reg_2 <= 4'd0;
      end else begin
         r_fwd_en   <= wr_en;
         r_fwd_reg  <= wr_reg;
         r_fwd_data <= wr_data;
         r_rd_reg_1 <= rd_reg_1;
         r_rd_reg_2 <= rd_reg_2;
      end
   end

   assign rd_data_1 = (r_fwd_en && (r_rd_reg_1 == r_fwd_reg)) ? r_fwd_data : rd_raw_1;
   assign rd_data_2 = (r_fwd_en && (r_rd_reg_2 == r_fwd_reg)) ? r_fwd_data : rd_raw_2;
`else
   logic w_unused_rd;
   assign w_unused_rd = ^{rd_reg_1, rd_reg_2};
   assign rd_data_1   = rd_raw_1;
   assign rd_data_2   = rd_raw_2;
`endif

endmodule

`default_nettype wire

// File: tb/tb_regs_wb.sv
//------------------------------------------------------------------------------
// tb_regs_wb : cycle-by-cycle vector table for regs_wb plus a forwarding sequence.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_regs_wb;

   logic        clk = 1'b0;
   logic        rst;
   logic        alu_valid;
   logic [3:0]  alu_reg;
   logic [31:0] alu_data;
   logic        ld_valid;
   logic [3:0]  ld_reg;
   logic [31:0] ld_data;
   logic        ld_ready;
   logic        wr_en;
   logic [3:0]  wr_reg;
   logic [31:0] wr_data;
   logic [3:0]  rd_reg_1, rd_reg_2;
   logic [31:0] rd_raw_1, rd_raw_2;
   logic [31:0] rd_data_1, rd_data_2;
   logic        busy;

   int checks = 0;
   int errors = 0;

   regs_wb dut (
      .clk(clk), .rst(rst),
      .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data),
      .ld_valid(ld_valid), .ld_reg(ld_reg), .ld_data(ld_data),
      .ld_ready(ld_ready),
      .wr_en(wr_en), .wr_reg(wr_reg), .wr_data(wr_data),
      .rd_reg_1(rd_reg_1), .rd_reg_2(rd_reg_2),
      .rd_raw_1(rd_raw_1), .rd_raw_2(rd_raw_2),
      .rd_data_1(rd_data_1), .rd_data_2(rd_data_2),
      .busy(busy)
   );

   always #5 clk = ~clk;

   // Inputs applied for one edge, outputs expected just after that edge.
   typedef struct {
      logic        rst;
      logic        av;
      logic [3:0]  ar;
      logic [31:0] ad;
      logic        lv;
      logic [3:0]  lr;
      logic [31:0] ldd;
      logic        we;
      logic [3:0]  wr;
      logic [31:0] wd;
      logic        chk_d;
      logic        busy;
      logic        rdy;
   } vec_t;

   localparam int NV = 26;
   vec_t tbl [NV];

   task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
      end
   endtask

   initial begin
      //           rst  av   ar     ad            lv   lr      ldd           we   wr     wd            cd   busy rdy
      tbl[0]  = '{1'b1,1'b0,4'd0, 32'h0,        1'b1,4'd8,  32'h88,       1'b0,4'd0, 32'h0,        1'b1,1'b0,1'b1};
      tbl[1]  = '{1'b0,1'b0,4'd0, 32'h0,        1'b0,4'd0,  32'h0,        1'b0,4'd0, 32'h0,        1'b0,1'b0,1'b1};
      tbl[2]  = '{1'b0,1'b1,4'd3, 32'h11111111, 1'b0,4'd0,  32'h0,        1'b1,4'd3, 32'h11111111, 1'b1,1'b0,1'b1};
      tbl[3]  = '{1'b0,1'b1,4'd1, 32'hA,        1'b1,4'd2,  32'hB,        1'b1,4'd1, 32'hA,        1'b1,1'b1,1'b1};
      tbl[4]  = '{1'b0,1'b0,4'd0, 32'h0,        1'b0,4'd0,  32'h0,        1'b1,4'd2, 32'hB,        1'b1,1'b0,1'b1};
      tbl[5]  = '{1'b0,1'b0,4'd0, 32'h0,        1'b0,4'd0,  32'h0,        1'b0,4'd0, 32'h0,        1'b0,1'b0,1'b1};
      tbl[6]  = '{1'b0,1'b1,4'd1, 32'h1,        1'b1,4'd4,  32'h40,       1'b1,4'd1, 32'h1,        1'b1,1'b1,1'b1};
      tbl[7]  = '{1'b0,1'b1,4'd2, 32'h2,        1'b1,4'd5,  32'h50,       1'b1,4'd2, 32'h2,        1'b1,1'b1,1'b0};
      tbl[8]  = '{1'b0,1'b1,4'd3, 32'h3,        1'b1,4'd6,  32'h60,       1'b1,4'd3, 32'h3,        1'b1,1'b1,1'b0};
      tbl[9]  = '{1'b0,1'b0,4'd0, 32'h0,        1'b1,4'd6,  32'h60,       1'b1,4'd4, 32'h40,       1'b1,1'b1,1'b1};
      tbl[10] = '{1'b0,1'b0,4'd0, 32'h0,        1'b1,4'd6,  32'h60,       1'b1,4'd5, 32'h50,       1'b1,1'b1,1'b1};
      tbl[11] = '{1'b0,1'b0,4'd0, 32'h0,        1'b0,4'd0,  32'h0,        1'b1,4'd6, 32'h60,       1'b1,1'b0,1'b1};
      tbl[12] = '{1'b0,1'b1,4'd1, 32'h1,        1'b1,4'd7,  32'hC,        1'b1,4'd1, 32'h1,        1'b1,1'b1,1'b1};
      tbl[13] = '{1'b0,1'b1,4'd7, 32'hD,        1'b0,4'd0,  32'h0,        1'b1,4'd7, 32'hD,        1'b1,1'b0,1'b1};
      tbl[14] = '{1'b0,1'b0,4'd0, 32'h0,        1'b0,4'd0,  32'h0,        1'b0,4'd0, 32'h0,        1'b0,1'b0,1'b1};
      tbl[15] = '{1'b0,1'b1,4'd8, 32'hE,        1'b1,4'd8,  32'hF,        1'b1,4'd8, 32'hE,        1'b1,1'b0,1'b1};
      tbl[16] = '{1'b0,1'b0,4'd0, 32'h0,        1'b0,4'd0,  32'h0,        1'b0,4'd0, 32'h0,        1'b0,1'b0,1'b1};
      tbl[17] = '{1'b0,1'b1,4'd1, 32'h1,        1'b1,4'd9,  32'h90,       1'b1,4'd1, 32'h1,        1'b1,1'b1,1'b1};
      tbl[18] = '{1'b0,1'b1,4'd2, 32'h2,        1'b1,4'd10, 32'hA0,       1'b1,4'd2, 32'h2,        1'b1,1'b1,1'b0};
      tbl[19] = '{1'b0,1'b1,4'd9, 32'h99,       1'b0,4'd0,  32'h0,        1'b1,4'd9, 32'h99,       1'b1,1'b1,1'b1};
      tbl[20] = '{1'b0,1'b0,4'd0, 32'h0,        1'b0,4'd0,  32'h0,        1'b1,4'd10,32'hA0,       1'b1,1'b0,1'b1};
      tbl[21] = '{1'b0,1'b0,4'd0, 32'h0,        1'b1,4'd11, 32'hB0,       1'b1,4'd11,32'hB0,       1'b1,1'b0,1'b1};
      tbl[22] = '{1'b0,1'b1,4'd1, 32'h1,        1'b1,4'd12, 32'hC0,       1'b1,4'd1, 32'h1,        1'b1,1'b1,1'b1};
      tbl[23] = '{1'b0,1'b1,4'd2, 32'h2,        1'b1,4'd13, 32'hD0,       1'b1,4'd2, 32'h2,        1'b1,1'b1,1'b0};
      tbl[24] = '{1'b1,1'b0,4'd0, 32'h0,        1'b0,4'd0,  32'h0,        1'b0,4'd0, 32'h0,        1'b1,1'b0,1'b1};
      tbl[25] = '{1'b0,1'b0,4'd0, 32'h0,        1'b0,4'd0,  32'h0,        1'b0,4'd0, 32'h0,        1'b0,1'b0,1'b1};

      rst = 1'b1; alu_valid = 1'b0; alu_reg = '0; alu_data = '0;
      ld_valid = 1'b0; ld_reg = '0; ld_data = '0;
      rd_reg_1 = '0; rd_reg_2 = '0; rd_raw_1 = '0; rd_raw_2 = '0;
      repeat (2) @(posedge clk);

      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         rst = tbl[i].rst;
         alu_valid = tbl[i].av; alu_reg = tbl[i].ar; alu_data = tbl[i].ad;
         ld_valid = tbl[i].lv; ld_reg = tbl[i].lr; ld_data = tbl[i].ldd;
         @(posedge clk);
         #1;
         chk("wr_en", i, {31'd0, wr_en}, {31'd0, tbl[i].we});
         chk("busy", i, {31'd0, busy}, {31'd0, tbl[i].busy});
         chk("ld_ready", i, {31'd0, ld_ready}, {31'd0, tbl[i].rdy});
         if (tbl[i].chk_d) begin
            chk("wr_reg", i, {28'd0, wr_reg}, {28'd0, tbl[i].wr});
            chk("wr_data", i, wr_data, tbl[i].wd);
         end
      end

      // Forwarding: r9 is written at the edge that samples rd_reg_1=9.
      @(negedge clk);
      rst = 1'b0; ld_valid = 1'b0;
      alu_valid = 1'b1; alu_reg = 4'd9; alu_data = 32'h5A5A5A5A;
      @(negedge clk);
      alu_valid = 1'b0;
      rd_reg_1 = 4'd9; rd_reg_2 = 4'd4;
      rd_raw_1 = 32'h0BADF00D; rd_raw_2 = 32'h00001234;
      @(posedge clk);
      #1;
`ifdef REGS_WB_FWD_EN
      chk("fwd_hit_1", 100, rd_data_1, 32'h5A5A5A5A);
`else
      chk("fwd_hit_1", 100, rd_data_1, 32'h0BADF00D);
`endif
      chk("fwd_miss_2", 101, rd_data_2, 32'h00001234);
      @(negedge clk);
      rd_raw_1 = 32'h00000077;
      @(posedge clk);
      #1;
      chk("fwd_none_1", 102, rd_data_1, 32'h00000077);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
